pkt_tx_rd: RTL and testbench



---
 rtl/pkt_tx_rd.sv | 154 +++++++++++++++
 tb/tb_pkt_tx_rd.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_rd.sv
// Per-channel packet read engine: pops a descriptor, streams the stored packet
// (minus routing header) out of the packet RAM through a small skid FIFO.
module pkt_tx_rd #(
   parameter int RAM_DEPTH  = 11,
   parameter int HDR_WORDS  = 1,
   parameter int SKID_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pkt_rdy,
   output logic                 fifo_rden,
   input  logic [23:0]          fifo_dout,
   output logic [RAM_DEPTH-1:0] ram_raddr,
   input  logic [15:0]          ram_dout,
   output logic [15:0]          out_data,
   output logic                 out_sof,
   output logic                 out_eof,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 drop_pulse,
   output logic [15:0]          pkt_cnt
);

   localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int CW = $clog2(SKID_DEPTH + 1) + 1;
   localparam logic [9:0]           HDR_L = 10'(HDR_WORDS);
   localparam logic [RAM_DEPTH-1:0] HDR_A = RAM_DEPTH'(HDR_WORDS);

   typedef enum logic [2:0] {IDLE, DESC_RD, DESC_W1, DESC_W2, CHECK, STREAM, DRAIN} state_t;
   state_t state, state_nxt;

   logic [9:0]           pkt_len;
   logic [RAM_DEPTH-1:0] start_addr;
   logic [2:0]           unused_rsvd;
   logic [RAM_DEPTH-1:0] rd_addr;
   logic [9:0]           words_left;
   logic                 first_pend;
   logic                 vld_p0, vld_p1;
   logic                 sof_p0, sof_p1, eof_p0, eof_p1;
   logic [17:0]          skid_mem [SKID_DEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count, in_flight;
   logic                 issue, load, pkt_done, push, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pkt_len     = fifo_dout[20:11];
   assign start_addr  = fifo_dout[RAM_DEPTH-1:0];
   assign unused_rsvd = fifo_dout[23:21];
   assign in_flight   = CW'(vld_p0) + CW'(vld_p1);
   assign ram_raddr   = rd_addr;
   assign busy        = (state != IDLE);
   assign push        = vld_p1;
   assign out_valid   = (count != '0);
   assign pop         = out_valid & out_ready;
   assign out_data    = out_valid ? skid_mem[rd_ptr][15:0] : '0;
   assign out_sof     = out_valid & skid_mem[rd_ptr][16];
   assign out_eof     = out_valid & skid_mem[rd_ptr][17];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      fifo_rden  = 1'b0;
      drop_pulse = 1'b0;
      issue      = 1'b0;
      load       = 1'b0;
      pkt_done   = 1'b0;
      case (state)
         IDLE:    if (pkt_rdy) state_nxt = DESC_RD;
         DESC_RD: begin
            fifo_rden = 1'b1;
            state_nxt = DESC_W1;
         end
         DESC_W1: state_nxt = DESC_W2;
         DESC_W2: state_nxt = CHECK;
         CHECK: begin
            if (pkt_len > HDR_L) begin
               load      = 1'b1;
               state_nxt = STREAM;
            end else begin
               drop_pulse = 1'b1;
               state_nxt  = IDLE;
            end
         end
         STREAM: begin
            // Skid credit ignores a same-cycle pop, so it can never overflow.
            if (words_left == '0) begin
               state_nxt = DRAIN;
            end else if ((count + in_flight) < CW'(SKID_DEPTH)) begin
               issue = 1'b1;
               if (words_left == 10'd1) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (in_flight == '0 && count == '0) begin
               pkt_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr    <= '0;
         words_left <= '0;
         first_pend <= 1'b0;
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pkt_cnt    <= '0;
      end else begin
         if (load) begin
            rd_addr    <= start_addr + HDR_A;
            words_left <= pkt_len - HDR_L;
            first_pend <= 1'b1;
         end else if (issue) begin
            rd_addr    <= rd_addr + RAM_DEPTH'(1);
            words_left <= words_left - 10'd1;
            first_pend <= 1'b0;
         end
         // p0: address issued last cycle; p1: RAM data lands this cycle
         vld_p0 <= issue;
         vld_p1 <= vld_p0;
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
         if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      sof_p0 <= first_pend;
      eof_p0 <= (words_left == 10'd1);
      sof_p1 <= sof_p0;
      eof_p1 <= eof_p0;
      if (push) skid_mem[wr_ptr] <= {eof_p1, sof_p1, ram_dout};
   end

endmodule

// File: tb/tb_pkt_tx_rd.sv
// Bench for pkt_tx_rd: descriptor FIFO and 2-cycle RAM models, a word-list
// reference model built from each descriptor, and a stream scoreboard.
module tb_pkt_tx_rd;

   logic        clk = 1'b0, rst = 1'b1, pkt_rdy = 1'b0, fifo_rden;
   logic [23:0] fifo_dout = '0;
   logic [10:0] ram_raddr;
   logic [15:0] ram_dout = '0, out_data, pkt_cnt;
   logic        out_sof, out_eof, out_valid, out_ready = 1'b1, busy, drop_pulse;

   pkt_tx_rd dut (
      .clk(clk), .rst(rst), .pkt_rdy(pkt_rdy), .fifo_rden(fifo_rden), .fifo_dout(fifo_dout),
      .ram_raddr(ram_raddr), .ram_dout(ram_dout), .out_data(out_data), .out_sof(out_sof),
      .out_eof(out_eof), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .drop_pulse(drop_pulse), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] data; logic sof; logic eof; } word_t;
   typedef struct { int len; int start; bit rnd; int exp_words; int exp_drop; int exp_raddr; } vec_t;

   word_t       exp_q[$];
   logic [23:0] desc_q[$];
   logic [15:0] ram [2048];
   logic [15:0] ram_p1 = '0;
   logic [23:0] fifo_p1 = '0;
   vec_t        vecs[6];

   int n_checks = 0, n_fail = 0;
   int cyc = 0, rden_cyc = -100, last_rden = -100, first_valid_cyc = -1, last_valid_cyc = -1;
   int acc_words = 0, drops = 0, stall_n = 0;
   bit rand_ready = 1'b0;
   logic [10:0] raddr_t4 = '0;
   logic        prev_stall = 1'b0, prev_sof = 1'b0, prev_eof = 1'b0;
   logic [15:0] prev_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   // Reference model: forwarded words are stored words HDR_WORDS..len-1.
   task automatic push_desc(input int len, input int start);
      desc_q.push_back({3'b000, 10'(len), 11'(start)});
      for (int i = 1; i < len; i++) begin
         int a;
         a = (start + i) % 2048;
         exp_q.push_back('{ram[a], (i == 1), (i == len - 1)});
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_fifo_rden"}, 32'(fifo_rden), 0);
      check({tag, "_ram_raddr"}, 32'(ram_raddr), 0);
      check({tag, "_out_data"}, 32'(out_data), 0);
      check({tag, "_out_sof"}, 32'(out_sof), 0);
      check({tag, "_out_eof"}, 32'(out_eof), 0);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_drop_pulse"}, 32'(drop_pulse), 0);
      check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 0);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      while (!done && n < budget) begin
         @(negedge clk); #1;
         n++;
         done = (desc_q.size() == 0) && !pkt_rdy && !busy && (exp_q.size() == 0);
      end
      check(name, 32'(done), 1);
   endtask

   task automatic wait_words(input int target, input int budget);
      int n;
      n = 0;
      while (acc_words < target && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      check("words_reached", 32'(acc_words >= target), 1);
   endtask

   // Descriptor FIFO: data appears two cycles after the read strobe and holds.
   always @(posedge clk) begin
      if (fifo_rden && desc_q.size() != 0) begin
         fifo_p1 <= desc_q[0];
         void'(desc_q.pop_front());
      end
      fifo_dout <= fifo_p1;
      pkt_rdy   <= (desc_q.size() != 0);
   end

   always @(posedge clk) begin
      ram_p1   <= ram[ram_raddr];
      ram_dout <= ram_p1;
   end

   initial forever begin
      @(posedge clk); #1;
      if (stall_n > 0) begin
         out_ready = 1'b0;
         stall_n--;
      end else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
   end

   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst) prev_stall = 1'b0;
      else begin
         if (fifo_rden) begin
            check("rden_spacing", 32'((cyc - last_rden) >= 4), 1);
            last_rden = cyc;
            rden_cyc  = cyc;
         end
         if (cyc == rden_cyc + 4) raddr_t4 = ram_raddr;
         if (drop_pulse) drops++;
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 1);
            check("stall_data", 32'(out_data), 32'(prev_data));
            check("stall_tags", 32'({out_sof, out_eof}), 32'({prev_sof, prev_eof}));
         end
         if (out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            acc_words++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: actual %0h, required none", out_data);
            end else begin
               word_t e;
               e = exp_q.pop_front();
               check("word_data", 32'(out_data), 32'(e.data));
               check("word_sof", 32'(out_sof), 32'(e.sof));
               check("word_eof", 32'(out_eof), 32'(e.eof));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_sof   = out_sof;
         prev_eof   = out_eof;
      end
   end

   initial begin
      logic [15:0] cnt0;
      logic [10:0] ra0;
      int          drops0, nd, len;

      for (int i = 0; i < 2048; i++) ram[i] = 16'($urandom);
      vecs[0] = '{190, 'h100, 1'b0, 189, 0, 'h101};
      vecs[1] = '{5,   'h7FE, 1'b0, 4,   0, 'h7FF};
      vecs[2] = '{1,   'h050, 1'b0, 0,   1, 0};
      vecs[3] = '{0,   'h060, 1'b0, 0,   1, 0};
      vecs[4] = '{2,   'h200, 1'b0, 1,   0, 'h201};
      vecs[5] = '{37,  'h3F0, 1'b1, 36,  0, 'h3F1};

      repeat (3) @(negedge clk);
      #1 check_reset("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rand_ready      = vecs[i].rnd;
         cnt0            = pkt_cnt;
         drops0          = drops;
         ra0             = ram_raddr;
         acc_words       = 0;
         first_valid_cyc = -1;
         push_desc(vecs[i].len, vecs[i].start);
         wait_idle(4000, "vec_idle");
         check("vec_words", 32'(acc_words), 32'(vecs[i].exp_words));
         check("vec_drops", 32'(drops - drops0), 32'(vecs[i].exp_drop));
         check("vec_pkt_cnt", 32'(pkt_cnt), 32'(16'(cnt0 + ((vecs[i].exp_drop != 0) ? 0 : 1))));
         if (vecs[i].exp_drop != 0) check("vec_no_ram_read", 32'(ram_raddr), 32'(ra0));
         else if (!vecs[i].rnd) begin
            check("vec_first_raddr", 32'(raddr_t4), 32'(vecs[i].exp_raddr));
            check("vec_first_valid_lat", 32'(first_valid_cyc - rden_cyc), 7);
            check("vec_gapless", 32'(last_valid_cyc - first_valid_cyc + 1), 32'(vecs[i].exp_words));
         end
      end

      // Back-to-back drops: both discarded, strobes kept apart.
      @(negedge clk);
      rand_ready = 1'b0;
      cnt0 = pkt_cnt; drops0 = drops; ra0 = ram_raddr; acc_words = 0;
      push_desc(1, 'h010);
      push_desc(0, 'h020);
      wait_idle(200, "drop2_idle");
      check("drop2_drops", 32'(drops - drops0), 2);
      check("drop2_words", 32'(acc_words), 0);
      check("drop2_pkt_cnt", 32'(pkt_cnt), 32'(cnt0));
      check("drop2_raddr", 32'(ram_raddr), 32'(ra0));

      // Random backpressure plus a long stall in mid-packet.
      @(negedge clk);
      rand_ready = 1'b1;
      cnt0 = pkt_cnt; acc_words = 0;
      push_desc(60, 'h400);
      wait_words(20, 2000);
      stall_n = 20;
      wait_idle(4000, "stall_idle");
      check("stall_words", 32'(acc_words), 59);
      check("stall_pkt_cnt", 32'(pkt_cnt), 32'(16'(cnt0 + 1)));

      // Reset while streaming, then a clean packet.
      @(negedge clk);
      rand_ready = 1'b0;
      acc_words = 0;
      push_desc(100, 'h500);
      wait_words(10, 500);
      @(negedge clk); #2;
      rst = 1'b1;
      #1 check_reset("midrst");
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      acc_words = 0; first_valid_cyc = -1;
      push_desc(8, 'h600);
      wait_idle(500, "post_rst_idle");
      check("post_rst_words", 32'(acc_words), 7);
      check("post_rst_pkt_cnt", 32'(pkt_cnt), 1);
      check("post_rst_first_raddr", 32'(raddr_t4), 'h601);

      // Randomized descriptors under random backpressure.
      @(negedge clk);
      rand_ready = 1'b1;
      cnt0 = pkt_cnt; drops0 = drops; nd = 0;
      for (int i = 0; i < 12; i++) begin
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 40));
         if (len <= 1) nd++;
         push_desc(len, int'($urandom_range(0, 2047)));
      end
      wait_idle(8000, "rand_idle");
      check("rand_pkt_cnt", 32'(pkt_cnt), 32'(16'(cnt0 + 16'(12 - nd))));
      check("rand_drops", 32'(drops - drops0), 32'(nd));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
